// File: rtl/rx_unit.sv
// UART receiver: 16x oversampled, mid-bit sampling, runtime-selectable baud,
// parity, word length and stop bits. Results are presented with a one-clock rx_done.
module rx_unit (
    input  logic       clock,
    input  logic       rst,
    input  logic       data_tx,
    input  logic [1:0] baud_rate,
    input  logic [1:0] parity_type,
    input  logic       data_length,
    input  logic       stop_bits,
    output logic [7:0] data_out,
    output logic       rx_active,
    output logic       rx_done,
    output logic       parity_error,
    output logic       stop_error
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic        sync1_q, sync2_q, prev_q, armed_q;
    logic        prev_d, armed_d;
    logic [1:0]  settle_q, settle_d;
    logic [10:0] div_q, div_d, div_max;
    logic [3:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_acc_q, par_acc_d;
    logic        perr_q, perr_d;
    logic        serr_q, serr_d;
    logic [1:0]  baud_q, baud_d, ptype_q, ptype_d;
    logic        len_q, len_d, stop2_q, stop2_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        perr_out_q, perr_out_d, serr_out_q, serr_out_d;
    logic [1:0]  baud_sel;
    logic        fall, start, tick, sample, par_en, last_data;

    // The line is only armed once a genuine high has been seen after reset, so the
    // reset value of the synchronizer cannot fake a start edge on a line held low.
    assign fall      = armed_q & prev_q & ~sync2_q;
    assign start     = (state_q == S_IDLE) & fall;
    assign baud_sel  = (state_q == S_IDLE) ? baud_rate : baud_q;
    assign tick      = (div_q >= div_max);
    assign sample    = tick & (tick_cnt_q == 4'd7);
    assign par_en    = ptype_q[0] ^ ptype_q[1];
    assign last_data = len_q ? (bit_cnt_q == 3'd7) : (bit_cnt_q == 3'd6);

    always_comb begin
        div_max = 11'd1301;
        case (baud_sel)
            2'b00:   div_max = 11'd1301;
            2'b01:   div_max = 11'd650;
            2'b10:   div_max = 11'd325;
            default: div_max = 11'd162;
        endcase
    end

    always_comb begin
        prev_d     = sync2_q;
        settle_d   = settle_q[1] ? settle_q : settle_q + 2'd1;
        armed_d    = armed_q | (settle_q[1] & sync2_q);
        div_d      = (start || tick) ? 11'd0 : div_q + 11'd1;
        tick_cnt_d = start ? 4'd0 : (tick ? tick_cnt_q + 4'd1 : tick_cnt_q);
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_acc_d  = par_acc_q;
        perr_d     = perr_q;
        serr_d     = serr_q;
        baud_d     = baud_q;
        ptype_d    = ptype_q;
        len_d      = len_q;
        stop2_d    = stop2_q;
        data_out_d = data_out_q;
        perr_out_d = perr_out_q;
        serr_out_d = serr_out_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d   = S_START;
                baud_d    = baud_rate;
                ptype_d   = parity_type;
                len_d     = data_length;
                stop2_d   = stop_bits;
                bit_cnt_d = 3'd0;
                shift_d   = 8'd0;
                par_acc_d = 1'b0;
                perr_d    = 1'b0;
                serr_d    = 1'b0;
            end
            S_START: if (sample) begin
                state_d   = sync2_q ? S_IDLE : S_DATA;
                bit_cnt_d = 3'd0;
            end
            S_DATA: if (sample) begin
                shift_d[bit_cnt_q] = sync2_q;
                par_acc_d = par_acc_q ^ sync2_q;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (last_data) begin
                    state_d   = par_en ? S_PARITY : S_STOP;
                    bit_cnt_d = 3'd0;
                end
            end
            S_PARITY: if (sample) begin
                // ptype_q[0] is 1 for odd: the ones count including parity must equal it.
                perr_d  = par_acc_q ^ sync2_q ^ ptype_q[0];
                state_d = S_STOP;
            end
            S_STOP: if (sample) begin
                serr_d = serr_q | ~sync2_q;
                if (stop2_q && (bit_cnt_q == 3'd0)) begin
                    bit_cnt_d = 3'd1;
                end else begin
                    state_d    = S_DONE;
                    data_out_d = shift_q;
                    perr_out_d = par_en & perr_q;
                    serr_out_d = serr_q | ~sync2_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            settle_q   <= 2'd0;
            armed_q    <= 1'b0;
            div_q      <= 11'd0;
            tick_cnt_q <= 4'd0;
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            par_acc_q  <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            baud_q     <= 2'd0;
            ptype_q    <= 2'd0;
            len_q      <= 1'b0;
            stop2_q    <= 1'b0;
            data_out_q <= 8'd0;
            perr_out_q <= 1'b0;
            serr_out_q <= 1'b0;
        end else begin
            sync1_q    <= data_tx;
            sync2_q    <= sync1_q;
            prev_q     <= prev_d;
            settle_q   <= settle_d;
            armed_q    <= armed_d;
            div_q      <= div_d;
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_acc_q  <= par_acc_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
            baud_q     <= baud_d;
            ptype_q    <= ptype_d;
            len_q      <= len_d;
            stop2_q    <= stop2_d;
            data_out_q <= data_out_d;
            perr_out_q <= perr_out_d;
            serr_out_q <= serr_out_d;
        end
    end

    assign data_out     = data_out_q;
    assign parity_error = perr_out_q;
    assign stop_error   = serr_out_q;
    assign rx_active    = (state_q != S_IDLE);
    assign rx_done      = (state_q == S_DONE);

endmodule

// File: doc/rx_unit.md
RX_UNIT -- requirements
Module: rx_unit

Interface
REQ-001 The block SHALL have exactly one clock and one reset, using these ports:
- `clock`  in  1  system clock, 50 MHz, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.

REQ-002 The block SHALL have these inputs:
- `data_tx`  in  1  serial line, idle high, asynchronous to `clock`.
- `baud_rate`  in  2  00=2400, 01=4800, 10=9600, 11=19200 baud.
- `parity_type`  in  2  01=odd, 10=even, 00/11=no parity bit.
- `data_length`  in  1  0=7 data bits, 1=8 data bits.
- `stop_bits`  in  1  0=one stop bit, 1=two stop bits.

REQ-003 The block SHALL have these outputs:
- `data_out`  out  8  received word, LSB = first data bit.
- `rx_active`  out  1  high while a frame is being received.
- `rx_done`  out  1  one-clock pulse at end of frame.
- `parity_error`  out  1  parity mismatch on last frame.
- `stop_error`  out  1  a stop bit sampled low on last frame.

Function
REQ-004 `data_tx` SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.

REQ-005 The oversample tick SHALL be 16x baud, from a divider reloading at 1302/651/326/163 clocks for `baud_rate` 00/01/10/11.

REQ-006 The divider SHALL free-run from reset and SHALL restart at count 0 when a falling edge is detected in IDLE.

REQ-007 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP, DONE.

REQ-008 IDLE -> START SHALL occur on a synchronized 1->0 transition.

REQ-009 `baud_rate`, `parity_type`, `data_length` and `stop_bits` SHALL be latched at that transition and held for the whole frame.

REQ-010 Each bit SHALL be sampled once, at tick 7 of its 16-tick bit period (mid-bit).

REQ-011 START: if the mid-bit sample is high, the FSM SHALL return to IDLE (false start) with no `rx_done` and no flag change; otherwise it SHALL go to DATA.

REQ-012 DATA SHALL shift in 7 or 8 bits, LSB first.

REQ-013 After DATA, the FSM SHALL go to PARITY if parity is enabled, else to STOP.

REQ-014 PARITY SHALL sample one bit and compare it with the XOR of the received data bits:
- odd: the parity bit makes the total count of ones odd;
- even: the parity bit makes the total count of ones even.

REQ-015 STOP SHALL sample 1 or 2 stop bits; any low sample SHALL set the internal stop-error bit.

REQ-016 After the last stop-bit sample, STOP SHALL go to DONE.

REQ-017 DONE SHALL last exactly one clock, then go to IDLE.

REQ-018 In DONE, the block SHALL:
- load `data_out` with the received word;
- load `parity_error` and `stop_error`;
- assert `rx_done` for that clock only.

REQ-019 For 7-bit frames, `data_out[7]` SHALL be 0.

REQ-020 `parity_error` SHALL be 0 whenever parity is disabled.

REQ-021 Frame latency SHALL be: `rx_done` asserts within 1 clock after the mid-bit sample of the final stop bit, with no wait for the stop-bit end.

REQ-022 `data_out` and both error flags SHALL hold their value until the next DONE; an aborted or false-start frame SHALL NOT change them.

REQ-023 `rx_active` SHALL be high in the states START through DONE inclusive and low in IDLE.

REQ-024 A new start edge SHALL be accepted in the first IDLE clock after DONE (back-to-back frames).

REQ-025 Changes to the configuration inputs mid-frame SHALL have no effect until the next start edge.

REQ-026 A line held low (break) SHALL give one frame with `stop_error`=1; no further frame SHALL start until the line has returned high and fallen again.

REQ-027 No buffering is provided: `rx_done` SHALL be the only data-valid indication.

Reset
REQ-028 When `rst`=0, all outputs SHALL go to 0, the FSM to IDLE, the divider to 0 and the synchronizer flops to 1, immediately and asynchronously.

REQ-029 Reset released mid-frame SHALL resume in IDLE; a line already low SHALL NOT be treated as a start until a 1->0 transition is seen.

Verification
REQ-030 The bench SHALL cover these directed scenarios (stimulus -> required response):
- 9600 baud, 8 data, no parity, 1 stop, byte 0xA5 -> one `rx_done` pulse, `data_out`=0xA5, both errors 0, `rx_active` high for ~9.5 bit times.
- 19200 baud, 7 data, even parity, 2 stop, data 0x55 with parity bit 0 -> `data_out`=0x55, `parity_error`=0; same frame with parity bit 1 -> `parity_error`=1.
- 2400 baud, 8 data, odd parity, 0x00 with parity bit 1, stop bit driven low -> `data_out`=0x00, `parity_error`=0, `stop_error`=1.
- 0.3-bit low glitch on an idle line at 9600 baud -> no `rx_done`; FSM back in IDLE; `data_out` unchanged.
- Two back-to-back 8N1 frames 0x3C then 0xC3 with zero idle gap -> two `rx_done` pulses, values in order.
- `rst` pulsed low mid-DATA -> all outputs 0 within the same clock; the next full frame 0x81 is received correctly.
